// File: rtl/seq_word_serializer.sv
// seq_word_serializer: one-word-buffered parallel-to-serial feeder for the sequence detector.
// Rev 1.0 - initial release.
`default_nettype none

module seq_word_serializer #(
   parameter int   WORD_W   = 8,
   parameter int   CNT_W    = 16,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              msb_first,
   output logic              data_out,
   output logic              bit_valid,
   output logic              word_start,
   output logic [CNT_W-1:0]  word_count
);

   localparam int              BC_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] hold_reg;
   logic              hold_full;
   logic              hold_msb;
   logic [WORD_W-1:0] shift_reg;
   logic              shift_msb;
   logic [BC_W-1:0]   bit_cnt;
   logic              load;
   logic              last_bit;
   logic              capture;

   // Capture and load are mutually exclusive: one needs an empty holder, the other a full one.
   assign capture = in_valid && !hold_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            if (hold_full) begin
               state_nxt = SHIFT;
               load      = 1'b1;
            end
         end
         SHIFT: begin
            if (bit_cnt == LAST_BIT) begin
               last_bit = 1'b1;
               if (hold_full) load      = 1'b1;
               else           state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_reg  <= '0;
         hold_msb  <= 1'b0;
         hold_full <= 1'b0;
      end else if (capture) begin
         hold_reg  <= in_data;
         hold_msb  <= msb_first;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   // Bit order travels with the word so a mid-word msb_first change cannot corrupt it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg <= '0;
         shift_msb <= 1'b0;
         bit_cnt   <= '0;
      end else if (load) begin
         shift_reg <= hold_reg;
         shift_msb <= hold_msb;
         bit_cnt   <= '0;
      end else if (state == SHIFT) begin
         bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
         shift_reg <= shift_msb ? {shift_reg[WORD_W-2:0], 1'b0}
                                : {1'b0, shift_reg[WORD_W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      word_count <= '0;
      else if (last_bit) word_count <= word_count + 1'b1;
   end

   assign in_ready   = !hold_full;
   assign bit_valid  = (state == SHIFT);
   assign word_start = bit_valid && (bit_cnt == '0);
   assign data_out   = bit_valid ? (shift_msb ? shift_reg[WORD_W-1] : shift_reg[0]) : IDLE_BIT;

endmodule

`default_nettype wire

// File: tb/tb_seq_word_serializer.sv
// Directed self-checking bench for seq_word_serializer (default instance plus a
// narrow-counter, idle-high instance).
`default_nettype none

module tb_seq_word_serializer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        msb_first;
   wire         in_ready;
   wire         data_out;
   wire         bit_valid;
   wire         word_start;
   wire  [15:0] word_count;

   logic [3:0]  in_data2;
   logic        in_valid2;
   logic        msb_first2;
   wire         in_ready2;
   wire         data_out2;
   wire         bit_valid2;
   wire         word_start2;
   wire  [1:0]  word_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_word_serializer dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .msb_first(msb_first), .data_out(data_out),
      .bit_valid(bit_valid), .word_start(word_start), .word_count(word_count)
   );

   seq_word_serializer #(.WORD_W(4), .CNT_W(2), .IDLE_BIT(1'b1)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_data(in_data2), .in_valid(in_valid2),
      .in_ready(in_ready2), .msb_first(msb_first2), .data_out(data_out2),
      .bit_valid(bit_valid2), .word_start(word_start2), .word_count(word_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Returns one time unit after the accepting edge.
   task automatic send8(input logic [7:0] d, input logic m);
      int n;
      n = 0;
      in_data   = d;
      msb_first = m;
      in_valid  = 1'b1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("send_ready_timeout", 32'(n < 50), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  e8;
      logic [15:0] e16;
      logic [23:0] stream;
      logic [19:0] w5;
      logic [7:0]  cnt5;
      logic [3:0]  w;
      logic        seen;
      int          got_bits;

      in_data = '0; in_valid = 1'b0; msb_first = 1'b0;
      in_data2 = '0; in_valid2 = 1'b0; msb_first2 = 1'b0;

      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_data_out", data_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_word_start", word_start, 0);
      check("rst_word_count", word_count, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // Test 1: single word, msb first.
      e8 = 8'hD0;
      send8(e8, 1'b1);
      check("t1_ready_low", in_ready, 0);
      check("t1_no_bit_yet", bit_valid, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t1_bit", data_out, e8[7-i]);
         check("t1_valid", bit_valid, 1);
         check("t1_start", word_start, 32'(i == 0));
         if (i == 1) check("t1_ready_back", in_ready, 1);
         if (i == 7) check("t1_count_before", word_count, 0);
      end
      tick();
      check("t1_idle_valid", bit_valid, 0);
      check("t1_idle_data", data_out, 0);
      check("t1_count", word_count, 1);

      // Test 2: back-to-back words with in_valid held.
      do_reset();
      e16 = 16'hAA55;
      in_data = 8'hAA; msb_first = 1'b1; in_valid = 1'b1;
      tick();
      in_data = 8'h55;
      tick();
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         if (k == 1) begin
            in_valid = 1'b0;
            check("t2_ready_full", in_ready, 0);
         end
         check("t2_bit", data_out, e16[15-k]);
         check("t2_valid", bit_valid, 1);
         if (k == 8) begin
            check("t2_start2", word_start, 1);
            check("t2_count_mid", word_count, 1);
         end
      end
      tick();
      check("t2_count", word_count, 2);
      check("t2_idle", bit_valid, 0);

      // Test 3: lsb first, msb_first toggled mid-word.
      do_reset();
      e8 = 8'h0B;
      send8(e8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 3) msb_first = 1'b1;
         check("t3_bit", data_out, e8[i]);
      end
      tick();
      check("t3_count", word_count, 1);

      // Test 4: three words offered while shifting; none lost or duplicated.
      do_reset();
      stream = {8'h3C, 8'hA5, 8'h0F};
      got_bits = 0;
      fork
         begin
            logic rb;
            logic acc;
            int   n;
            for (int wi = 0; wi < 3; wi++) begin
               in_data   = stream[23-8*wi -: 8];
               msb_first = 1'b1;
               in_valid  = 1'b1;
               acc = 1'b0;
               n = 0;
               while (!acc && n < 60) begin
                  rb = in_ready;
                  tick();
                  n++;
                  if (rb) acc = 1'b1;
               end
               check("t4_accept", acc, 1);
               check("t4_ready_low_held", in_ready, 0);
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 80 && got_bits < 24; c++) begin
               tick();
               if (bit_valid) begin
                  check("t4_bit", data_out, stream[23-got_bits]);
                  got_bits++;
               end
            end
         end
      join
      check("t4_bit_total", got_bits, 24);
      tick();
      check("t4_count", word_count, 3);
      check("t4_idle", bit_valid, 0);

      // Test 5: reset mid-word with a word held.
      send8(8'hFF, 1'b1);
      tick();
      in_data = 8'h81; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t5_held", in_ready, 0);
      tick();
      check("t5_shifting", bit_valid, 1);
      reset_n = 1'b0;
      #1;
      check("t5_data_out", data_out, 0);
      check("t5_bit_valid", bit_valid, 0);
      check("t5_word_start", word_start, 0);
      check("t5_in_ready", in_ready, 1);
      check("t5_word_count", word_count, 0);
      tick();
      reset_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         seen = seen | bit_valid | data_out;
      end
      check("t5_stays_idle", seen, 0);
      check("t5_count_after", word_count, 0);

      // Test 6: 2-bit counter wrap, idle-high fill between gapped words.
      w5   = {4'h6, 4'h9, 4'h3, 4'hC, 4'h5};
      cnt5 = {2'd1, 2'd2, 2'd3, 2'd0};
      for (int wi = 0; wi < 5; wi++) begin
         w = w5[19-4*wi -: 4];
         check("t6_idle_fill", data_out2, 1);
         check("t6_idle_valid", bit_valid2, 0);
         check("t6_ready", in_ready2, 1);
         in_data2 = w; msb_first2 = 1'b1; in_valid2 = 1'b1;
         tick();
         in_valid2 = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_bit", data_out2, w[3-i]);
            check("t6_start", word_start2, 32'(i == 0));
         end
         tick();
         if (wi < 4) check("t6_count", word_count2, cnt5[7-2*wi -: 2]);
         else        check("t6_count", word_count2, 1);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
